count_enable_gen: RTL and testbench

Upstream control stage for the 4-bit up-counter. It produces the counter's active-high `enable` as single-cycle pulses on a programmable prescale interval, in three modes:
- free-running;
- fixed-length burst;
- single-step.

It also reports `busy` and `done` so a sequencer can start a counting window and know when it finishes.

---
 rtl/count_enable_gen_pkg.sv | 13 +
 rtl/count_enable_gen_if.sv | 29 ++
 rtl/count_enable_gen_prescaler.sv | 46 ++++
 rtl/count_enable_gen.sv | 109 ++++++++++
 tb/tb_count_enable_gen.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/count_enable_gen_pkg.sv
// Shared types and default widths for the counter enable generator.
package count_enable_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2
   } cen_state_t;

   localparam int CEN_PRESCALE_W = 8;
   localparam int CEN_BURST_W    = 4;

endpackage

// File: rtl/count_enable_gen_if.sv
// Control/status bundle between a sequencer and the counter enable generator.
interface count_enable_gen_if
   import count_enable_pkg::*;
#(
   parameter int PRESCALE_W = CEN_PRESCALE_W,
   parameter int BURST_W    = CEN_BURST_W
) ();

   logic                  start;
   logic                  stop;
   logic                  step;
   logic                  mode_burst;
   logic [PRESCALE_W-1:0] prescale;
   logic [BURST_W-1:0]    burst_len;
   logic                  enable;
   logic                  busy;
   logic                  done;

   modport master (
      output start, stop, step, mode_burst, prescale, burst_len,
      input  enable, busy, done
   );

   modport slave (
      input  start, stop, step, mode_burst, prescale, burst_len,
      output enable, busy, done
   );

endinterface

// File: rtl/count_enable_gen_prescaler.sv
// Interval counter 0..period with a registered tick on every wrap.
module enable_prescaler
   import count_enable_pkg::*;
#(
   parameter int PERIOD_W = CEN_PRESCALE_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   input  logic                run,
   input  logic [PERIOD_W-1:0] period,
   output logic                tick
);

   logic [PERIOD_W-1:0] cnt_q, cnt_d;
   logic                tick_q, tick_d;

   // Wrap on >= so the count can never sit above the period
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clear) begin
         cnt_d = '0;
      end else if (run) begin
         if (cnt_q >= period) begin
            cnt_d  = '0;
            tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q + PERIOD_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/count_enable_gen.sv
// Enable pulse generator for the 4-bit up-counter: free-run, burst and single-step.
module count_enable_gen
   import count_enable_pkg::*;
#(
   parameter int PRESCALE_W = CEN_PRESCALE_W,
   parameter int BURST_W    = CEN_BURST_W
) (
   input  logic              clk,
   input  logic              reset,
   count_enable_gen_if.slave bus
);

   cen_state_t            state_q, state_d;
   logic [PRESCALE_W-1:0] period_q, period_d;
   logic [BURST_W-1:0]    burstCnt_q, burstCnt_d;
   logic                  stepReq_q, stepReq_d;
   logic                  enable_q, enable_d;
   logic                  busy_q;
   logic                  done_q, done_d;
   logic                  presClear, presRun, tick;
   logic [PRESCALE_W-1:0] presPeriod;

   // The prescaler starts on the accepting edge, one edge ahead of the
   // window, so its registered tick lines up with the registered enable.
   enable_prescaler #(.PERIOD_W(PRESCALE_W)) uPrescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (presClear),
      .run    (presRun),
      .period (presPeriod),
      .tick   (tick)
   );

   always_comb begin
      state_d    = state_q;
      period_d   = period_q;
      burstCnt_d = burstCnt_q;
      stepReq_d  = 1'b0;
      enable_d   = 1'b0;
      done_d     = 1'b0;
      presClear  = 1'b0;
      presRun    = 1'b0;
      presPeriod = period_q;
      case (state_q)
         IDLE: begin
            enable_d = stepReq_q;
            if (bus.start && (!bus.mode_burst || bus.burst_len != '0)) begin
               state_d    = bus.mode_burst ? BURST : RUN;
               period_d   = bus.prescale;
               burstCnt_d = bus.mode_burst ? bus.burst_len : '0;
               presPeriod = bus.prescale;
               presRun    = 1'b1;
            end else begin
               presClear = 1'b1;
               stepReq_d = bus.step && !bus.start;
            end
         end
         RUN, BURST: begin
            if (bus.stop) begin
               state_d    = IDLE;
               burstCnt_d = '0;
               presClear  = 1'b1;
            end else begin
               presRun  = 1'b1;
               enable_d = tick;
               if (state_q == BURST && tick) begin
                  burstCnt_d = burstCnt_q - BURST_W'(1);
                  // Last pulse of the burst: finish in the same cycle
                  if (burstCnt_q == BURST_W'(1)) begin
                     done_d    = 1'b1;
                     state_d   = IDLE;
                     presRun   = 1'b0;
                     presClear = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d   = IDLE;
            presClear = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         period_q   <= '0;
         burstCnt_q <= '0;
         stepReq_q  <= 1'b0;
         enable_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         burstCnt_q <= burstCnt_d;
         stepReq_q  <= stepReq_d;
         enable_q   <= enable_d;
         busy_q     <= (state_d != IDLE);
         done_q     <= done_d;
      end
   end

   assign bus.enable = enable_q;
   assign bus.busy   = busy_q;
   assign bus.done   = done_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Self-checking bench for count_enable_gen: vector table, burst/reset sequences, random vs model.
module tb_count_enable_gen;

   localparam int PW = 8;
   localparam int BW = 4;

   typedef struct {
      logic     rst;
      logic     start;
      logic     stop;
      logic     step;
      logic     mode;
      logic [PW-1:0] pre;
      logic [BW-1:0] len;
      logic [2:0]    exp;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   count_enable_gen_if #(.PRESCALE_W(PW), .BURST_W(BW)) bus ();

   count_enable_gen #(.PRESCALE_W(PW), .BURST_W(BW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checkCount = 0;
   int   passCount  = 0;
   vec_t tbl[$];

   // Reference model state: window start, latched settings, edges elapsed
   logic mActive = 1'b0;
   logic mBurst = 1'b0;
   logic mStepPend = 1'b0;
   int   mP = 0;
   int   mL = 0;
   int   mElapsed = 0;

   function automatic vec_t v(input logic r, s, sp, st, m, input int pre, len,
                              input logic e, b, d);
      vec_t x;
      x.rst = r; x.start = s; x.stop = sp; x.step = st; x.mode = m;
      x.pre = PW'(pre); x.len = BW'(len); x.exp = {e, b, d};
      return x;
   endfunction

   function automatic vec_t idleRow(input logic e, b, d);
      return v(0, 0, 0, 0, 0, 0, 0, e, b, d);
   endfunction

   task automatic addIdle(input int n, input logic e, b, d);
      for (int i = 0; i < n; i++) tbl.push_back(idleRow(e, b, d));
   endtask

   task automatic applyStimulus(input vec_t s);
      reset          = s.rst;
      bus.start      = s.start;
      bus.stop       = s.stop;
      bus.step       = s.step;
      bus.mode_burst = s.mode;
      bus.prescale   = s.pre;
      bus.burst_len  = s.len;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [2:0] exp);
      logic [2:0] act;
      act = {bus.enable, bus.busy, bus.done};
      checkCount++;
      if (act === exp) passCount++;
      else $display("[TB] FAIL %s: enable/busy/done got %b expected %b", name, act, exp);
   endtask

   // Expected outputs after one edge, from window arithmetic rather than states
   task automatic modelEdge(input vec_t s, output logic [2:0] exp);
      logic pulse;
      logic en;
      if (s.rst) begin
         mActive = 0; mStepPend = 0; mElapsed = 0;
         exp = 3'b000;
      end else if (mActive) begin
         mElapsed++;
         if (s.stop) begin
            mActive = 0;
            exp = 3'b000;
         end else begin
            pulse = (mElapsed % (mP + 1)) == 0;
            if (mBurst && pulse && (mElapsed / (mP + 1)) == mL) begin
               mActive = 0;
               exp = 3'b101;
            end else begin
               exp = {pulse, 1'b1, 1'b0};
            end
         end
      end else begin
         en = mStepPend;
         mStepPend = 0;
         if (s.start && (!s.mode || s.len != 0)) begin
            mActive = 1; mBurst = s.mode; mP = int'(s.pre); mL = int'(s.len);
            mElapsed = 0;
            exp = {en, 1'b1, 1'b0};
         end else begin
            mStepPend = s.step && !s.start;
            exp = {en, 1'b0, 1'b0};
         end
      end
   endtask

   task automatic burstSeq(input string tag, input int p, input int l);
      int   last;
      logic fin;
      last = l * (p + 1);
      applyStimulus(v(0, 1, 0, 0, 1, p, l, 0, 0, 0));
      checkOutput({tag, "_start"}, 3'b010);
      for (int k = 1; k <= last; k++) begin
         applyStimulus(idleRow(0, 0, 0));
         fin = (k == last);
         checkOutput($sformatf("%s_k%0d", tag, k), {(k % (p + 1)) == 0, !fin, fin});
      end
      applyStimulus(idleRow(0, 0, 0));
      checkOutput({tag, "_after"}, 3'b000);
      applyStimulus(idleRow(0, 0, 0));
      checkOutput({tag, "_after2"}, 3'b000);
   endtask

   initial begin
      vec_t       s;
      logic [2:0] e;

      // Reset, then free-run P=3 with stop at cycle 10; inputs change mid-window
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 1, 0, 0, 0, 3, 0, 0, 1, 0));
      addIdle(3, 0, 1, 0);
      addIdle(1, 1, 1, 0);
      addIdle(3, 0, 1, 0);
      addIdle(1, 1, 1, 0);
      addIdle(1, 0, 1, 0);
      tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      addIdle(3, 0, 0, 0);
      // start and step together: RUN with P=1, no step pulse
      tbl.push_back(v(0, 1, 0, 1, 0, 1, 0, 0, 1, 0));
      addIdle(1, 0, 1, 0);
      addIdle(1, 1, 1, 0);
      tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      addIdle(1, 0, 0, 0);
      // burst_len 0 is ignored
      tbl.push_back(v(0, 1, 0, 0, 1, 2, 0, 0, 0, 0));
      addIdle(2, 0, 0, 0);
      // stop on the wrap edge suppresses the pulse
      tbl.push_back(v(0, 1, 0, 0, 0, 2, 0, 0, 1, 0));
      addIdle(2, 0, 1, 0);
      tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      addIdle(1, 0, 0, 0);
      // single steps with gaps, then back-to-back steps
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      addIdle(1, 1, 0, 0);
      addIdle(1, 0, 0, 0);
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      addIdle(1, 1, 0, 0);
      addIdle(2, 0, 0, 0);
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
      addIdle(1, 1, 0, 0);
      addIdle(1, 0, 0, 0);
      // step during RUN adds nothing
      tbl.push_back(v(0, 1, 0, 0, 0, 3, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 1, 0, 0, 0, 0, 1, 0));
      addIdle(1, 0, 1, 0);
      addIdle(1, 1, 1, 0);
      tbl.push_back(v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      addIdle(2, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("tbl%0d", i), tbl[i].exp);
      end

      burstSeq("burst5p1", 1, 5);
      burstSeq("burst15p0", 0, 15);
      burstSeq("burst3p4", 4, 3);

      // Reset during the burst right after pulse 2 of 8
      applyStimulus(v(0, 1, 0, 0, 1, 1, 8, 0, 0, 0));
      checkOutput("rstmid_start", 3'b010);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(idleRow(0, 0, 0));
         checkOutput($sformatf("rstmid_k%0d", k), {(k % 2) == 0, 1'b1, 1'b0});
      end
      applyStimulus(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      checkOutput("rstmid_reset", 3'b000);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(idleRow(0, 0, 0));
         checkOutput($sformatf("rstmid_quiet%0d", k), 3'b000);
      end
      burstSeq("rerun8p1", 1, 8);

      // Random traffic against the reference model
      s = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      modelEdge(s, e);
      applyStimulus(s);
      checkOutput("rnd_reset", e);
      for (int i = 0; i < 3000; i++) begin
         s.rst   = ($urandom_range(0, 149) == 0);
         s.start = ($urandom_range(0, 7) == 0);
         s.stop  = ($urandom_range(0, 29) == 0);
         s.step  = ($urandom_range(0, 5) == 0);
         s.mode  = 1'($urandom_range(0, 1));
         s.pre   = PW'($urandom_range(0, 4));
         s.len   = BW'($urandom_range(0, 15));
         modelEdge(s, e);
         applyStimulus(s);
         checkOutput($sformatf("rnd%0d", i), e);
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
